// File: rtl/alu_pkg.sv
// Shared types and constants for the register-file ALU: opcodes, widths, instruction field positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int OPC_W    = 4;
    localparam int IMM_W    = 8;

    // Instruction field LSB positions. Register ops: opcode | rs1 | rs2 | rd.
    // LDI reuses the rs1 slot as its destination and the low byte as the immediate.
    localparam int OPC_LSB    = 12;
    localparam int RS1_LSB    = 8;
    localparam int RS2_LSB    = 4;
    localparam int RD_LSB     = 0;
    localparam int LDI_RD_LSB = 8;
    localparam int IMM_LSB    = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_NOT = 4'h6,
        OP_LDI = 4'hF
    } opcode_e;

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU: opcode + two operands + imm8 -> result, carry/borrow, zero, write/flag enables.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides whether the outputs are committed.
// Ports: opcode, a (rs1), b (rs2), imm8 in; result, carry, zero, writes_rd, sets_flags out.
module alu_datapath
    import alu_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [IMM_W-1:0]  imm8,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic              writes_rd,
    output logic              sets_flags
);

    opcode_e           op;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;

    assign op   = opcode_e'(opcode);
    // One extra bit on each side: sum[DATA_W] is the carry-out, and for the
    // subtraction the top bit goes high exactly when a < b (borrow).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result     = '0;
        carry      = 1'b0;
        writes_rd  = 1'b0;
        sets_flags = 1'b0;
        case (op)
            OP_ADD: begin
                result     = sum[DATA_W-1:0];
                carry      = sum[DATA_W];
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_SUB: begin
                result     = diff[DATA_W-1:0];
                carry      = diff[DATA_W];
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_AND: begin
                result     = a & b;
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_OR: begin
                result     = a | b;
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_XOR: begin
                result     = a ^ b;
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_NOT: begin
                result     = ~a;
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_LDI: begin
                // Writes a register but leaves both flags untouched.
                result     = {{(DATA_W-IMM_W){1'b0}}, imm8};
                writes_rd  = 1'b1;
            end
            default: begin
                // Unassigned opcodes are no-ops.
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_regfile_core.sv
// Single-cycle register-file ALU: 16 x 16-bit registers, one instruction per cycle, side-band seed port.
// Latency: operands read combinationally, result written at the clk edge where instr_valid=1.
// Backpressure: none; every valid instruction and every side-band write is accepted each cycle.
// Ports: clk, rst (async, active-high), instr_valid/instruction, wr_en/wr_addr/wr_data in;
//        registers[0:15], flag_z, flag_c out.
module alu_regfile_core
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instruction,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] registers [0:NUM_REGS-1],
    output logic              flag_z,
    output logic              flag_c
);

    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] dst;
    logic [IMM_W-1:0]  imm8;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              zero;
    logic              writes_rd;
    logic              sets_flags;
    logic              exec_we;

    assign opcode = instruction[OPC_LSB +: OPC_W];
    assign rs1    = instruction[RS1_LSB +: ADDR_W];
    assign rs2    = instruction[RS2_LSB +: ADDR_W];
    assign imm8   = instruction[IMM_LSB +: IMM_W];
    // LDI carries its destination in the rs1 slot.
    assign dst    = (opcode == OP_LDI) ? instruction[LDI_RD_LSB +: ADDR_W]
                                       : instruction[RD_LSB +: ADDR_W];

    alu_datapath u_datapath (
        .opcode     (opcode),
        .a          (registers[rs1]),
        .b          (registers[rs2]),
        .imm8       (imm8),
        .result     (result),
        .carry      (carry),
        .zero       (zero),
        .writes_rd  (writes_rd),
        .sets_flags (sets_flags)
    );

    assign exec_we = instr_valid && writes_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                registers[i] <= '0;
            end
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            // Side-band write takes priority when both target the same register.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && (wr_addr == ADDR_W'(i))) begin
                    registers[i] <= wr_data;
                end else if (exec_we && (dst == ADDR_W'(i))) begin
                    registers[i] <= result;
                end
            end
            if (instr_valid && sets_flags) begin
                flag_z <= zero;
                flag_c <= carry;
            end
        end
    end

endmodule

// File: tb/tb_alu_regfile_core.sv
module tb_alu_regfile_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instruction = 16'h0000;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'h0;
    logic [15:0] wr_data = 16'h0000;
    logic [15:0] registers [0:15];
    logic        flag_z;
    logic        flag_c;

    int          total = 0;
    int          bad = 0;
    logic [15:0] model [0:15];

    alu_regfile_core dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .registers   (registers),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    always #5 clk = ~clk;

    // Stimulus drivers: inputs change 1 time unit after the rising edge.
    task automatic seed(input logic [3:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        model[a] = d;
    endtask

    task automatic exec(input logic [15:0] ins);
        instruction = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (registers[i] !== 16'h0000) begin
                bad++;
                $display("FAIL reset_r%0d got=%h want=0000", i, registers[i]);
            end
        end
        total++;
        if (flag_z !== 1'b0 || flag_c !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got z=%b c=%b want z=0 c=0", flag_z, flag_c);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_ldi;
        exec(16'hF0AA);
        model[0] = 16'h00AA;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (registers[i] !== model[i]) begin
                bad++;
                $display("FAIL ldi_r%0d got=%h want=%h", i, registers[i], model[i]);
            end
        end
        total++;
        if (flag_z !== 1'b0 || flag_c !== 1'b0) begin
            bad++;
            $display("FAIL ldi_flags got z=%b c=%b want z=0 c=0", flag_z, flag_c);
        end
    endtask

    task automatic test_alu_basic;
        seed(4'd1, 16'h0010);
        seed(4'd2, 16'h0005);
        exec(16'h0123);
        model[3] = 16'h0015;
        total++;
        if (registers[3] !== 16'h0015 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
            bad++;
            $display("FAIL add got=%h z=%b c=%b want=0015 z=0 c=0", registers[3], flag_z, flag_c);
        end
        exec(16'h1124);
        model[4] = 16'h000B;
        total++;
        if (registers[4] !== 16'h000B || flag_z !== 1'b0 || flag_c !== 1'b0) begin
            bad++;
            $display("FAIL sub got=%h z=%b c=%b want=000b z=0 c=0", registers[4], flag_z, flag_c);
        end
        exec(16'h3125);
        model[5] = 16'h0000;
        total++;
        if (registers[5] !== 16'h0000 || flag_z !== 1'b1 || flag_c !== 1'b0) begin
            bad++;
            $display("FAIL and got=%h z=%b c=%b want=0000 z=1 c=0", registers[5], flag_z, flag_c);
        end
        exec(16'h4126);
        model[6] = 16'h0015;
        total++;
        if (registers[6] !== 16'h0015 || flag_z !== 1'b0) begin
            bad++;
            $display("FAIL or got=%h z=%b want=0015 z=0", registers[6], flag_z);
        end
        exec(16'h5127);
        model[7] = 16'h0015;
        total++;
        if (registers[7] !== 16'h0015 || flag_z !== 1'b0) begin
            bad++;
            $display("FAIL xor got=%h z=%b want=0015 z=0", registers[7], flag_z);
        end
        exec(16'h6108);
        model[8] = 16'hFFEF;
        total++;
        if (registers[8] !== 16'hFFEF || flag_z !== 1'b0 || flag_c !== 1'b0) begin
            bad++;
            $display("FAIL not got=%h z=%b c=%b want=ffef z=0 c=0", registers[8], flag_z, flag_c);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (registers[i] !== model[i]) begin
                bad++;
                $display("FAIL basic_r%0d got=%h want=%h", i, registers[i], model[i]);
            end
        end
    endtask

    task automatic test_wrap;
        seed(4'd1, 16'hFFFF);
        seed(4'd2, 16'h0001);
        exec(16'h0129);
        model[9] = 16'h0000;
        total++;
        if (registers[9] !== 16'h0000 || flag_z !== 1'b1 || flag_c !== 1'b1) begin
            bad++;
            $display("FAIL add_wrap got=%h z=%b c=%b want=0000 z=1 c=1", registers[9], flag_z, flag_c);
        end
        // LDI must not disturb the flags left by the ADD.
        exec(16'hFC7F);
        model[12] = 16'h007F;
        total++;
        if (registers[12] !== 16'h007F || flag_z !== 1'b1 || flag_c !== 1'b1) begin
            bad++;
            $display("FAIL ldi_keep got=%h z=%b c=%b want=007f z=1 c=1", registers[12], flag_z, flag_c);
        end
        exec(16'h121A);
        model[10] = 16'h0002;
        total++;
        if (registers[10] !== 16'h0002 || flag_z !== 1'b0 || flag_c !== 1'b1) begin
            bad++;
            $display("FAIL sub_borrow got=%h z=%b c=%b want=0002 z=0 c=1", registers[10], flag_z, flag_c);
        end
        exec(16'h312B);
        model[11] = 16'h0001;
        total++;
        if (registers[11] !== 16'h0001 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
            bad++;
            $display("FAIL and_clr_c got=%h z=%b c=%b want=0001 z=0 c=0", registers[11], flag_z, flag_c);
        end
    endtask

    task automatic test_noop_and_collision;
        exec(16'h012D);
        model[13] = 16'h0000;
        exec(16'h2123);
        instruction = 16'h0124;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        exec(16'hE123);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (registers[i] !== model[i]) begin
                bad++;
                $display("FAIL noop_r%0d got=%h want=%h", i, registers[i], model[i]);
            end
        end
        total++;
        if (flag_z !== 1'b1 || flag_c !== 1'b1) begin
            bad++;
            $display("FAIL noop_flags got z=%b c=%b want z=1 c=1", flag_z, flag_c);
        end
        // Same target: side-band wins.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
        exec(16'h5123);
        wr_en = 1'b0;
        model[3] = 16'hBEEF;
        total++;
        if (registers[3] !== 16'hBEEF) begin
            bad++;
            $display("FAIL collide_r3 got=%h want=beef", registers[3]);
        end
        // Different targets: both land on the same edge.
        wr_en = 1'b1; wr_addr = 4'd14; wr_data = 16'h1234;
        exec(16'hFF56);
        wr_en = 1'b0;
        model[14] = 16'h1234;
        model[15] = 16'h0056;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (registers[i] !== model[i]) begin
                bad++;
                $display("FAIL dual_r%0d got=%h want=%h", i, registers[i], model[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        seed(4'd1, 16'h0003);
        instruction = 16'h0111;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (registers[1] !== 16'h0006) begin
            bad++;
            $display("FAIL b2b_first got=%h want=0006", registers[1]);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        total++;
        if (registers[1] !== 16'h000C || flag_z !== 1'b0 || flag_c !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second got=%h z=%b c=%b want=000c z=0 c=0", registers[1], flag_z, flag_c);
        end
    endtask

    task automatic test_mid_reset;
        seed(4'd1, 16'hFFFF);
        exec(16'h0120);
        total++;
        if (registers[0] !== 16'h0000 || flag_c !== 1'b1 || flag_z !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset got=%h z=%b c=%b want=0000 z=1 c=1", registers[0], flag_z, flag_c);
        end
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h5555;
        instruction = 16'hF7AA;
        instr_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (registers[i] !== 16'h0000) begin
                bad++;
                $display("FAIL async_rst_r%0d got=%h want=0000", i, registers[i]);
            end
        end
        total++;
        if (flag_z !== 1'b0 || flag_c !== 1'b0) begin
            bad++;
            $display("FAIL async_rst_flags got z=%b c=%b want z=0 c=0", flag_z, flag_c);
        end
        @(posedge clk);
        #1;
        total++;
        if (registers[6] !== 16'h0000 || registers[7] !== 16'h0000) begin
            bad++;
            $display("FAIL rst_override got r6=%h r7=%h want 0000 0000", registers[6], registers[7]);
        end
        wr_en = 1'b0;
        instr_valid = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_alu_basic();
        test_wrap();
        test_noop_and_collision();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
